// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: fixed-priority (MEM over IFU) merge of two read masters onto one AXI read port
module axi_read_arbiter #(
    parameter int         ADDR_W = 32,
    parameter int         DATA_W = 64,
    parameter logic [3:0] IFU_ID = 4'd0,
    parameter logic [3:0] MEM_ID = 4'd1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] IFU_raddr,
    input  logic [2:0]        IFU_rsize,
    input  logic              IFU_raddr_valid,
    output logic              IFU_raddr_ready,
    output logic [DATA_W-1:0] IFU_rdata,
    output logic              IFU_rdata_valid,
    input  logic              IFU_rdata_ready,
    input  logic [ADDR_W-1:0] MEM_raddr,
    input  logic [2:0]        MEM_rsize,
    input  logic              MEM_raddr_valid,
    output logic              MEM_raddr_ready,
    output logic [DATA_W-1:0] MEM_rdata,
    output logic              MEM_rdata_valid,
    input  logic              MEM_rdata_ready,
    input  logic              io_master_arready,
    output logic              io_master_arvalid,
    output logic [ADDR_W-1:0] io_master_araddr,
    output logic [3:0]        io_master_arid,
    output logic [7:0]        io_master_arlen,
    output logic [2:0]        io_master_arsize,
    output logic [1:0]        io_master_arburst,
    output logic              io_master_rready,
    input  logic              io_master_rvalid,
    input  logic [DATA_W-1:0] io_master_rdata,
    input  logic [1:0]        io_master_rresp,
    input  logic              io_master_rlast,
    input  logic [3:0]        io_master_rid,
    output logic              ARB_error_signal
);
    typedef enum logic [1:0] {IDLE, AR, R} state_t;
    state_t state, state_n;
    logic owner_mem;
    logic [ADDR_W-1:0] araddr_q;
    logic [2:0] arsize_q;
    logic [3:0] arid_q;
    logic err_q;
    logic beat;
    assign io_master_araddr = araddr_q;
    assign io_master_arsize = arsize_q;
    assign io_master_arid = arid_q;
    assign io_master_arlen = 8'd0;
    assign io_master_arburst = 2'b01;
    assign ARB_error_signal = err_q;
    assign IFU_rdata = io_master_rdata;
    assign MEM_rdata = io_master_rdata;
    assign beat = (state == R) & io_master_rvalid & io_master_rready;
    // next state and handshake outputs; requests are held off while rst is asserted
    always_comb begin
        state_n = state;
        IFU_raddr_ready = 1'b0;
        MEM_raddr_ready = 1'b0;
        io_master_arvalid = 1'b0;
        io_master_rready = 1'b0;
        IFU_rdata_valid = 1'b0;
        MEM_rdata_valid = 1'b0;
        case (state)
            IDLE: begin
                MEM_raddr_ready = MEM_raddr_valid & ~rst;
                IFU_raddr_ready = IFU_raddr_valid & ~MEM_raddr_valid & ~rst;
                state_n = (MEM_raddr_ready | IFU_raddr_ready) ? AR : IDLE;
            end
            AR: begin
                io_master_arvalid = 1'b1;
                state_n = io_master_arready ? R : AR;
            end
            R: begin
                io_master_rready = owner_mem ? MEM_rdata_ready : IFU_rdata_ready;
                MEM_rdata_valid = owner_mem & io_master_rvalid;
                IFU_rdata_valid = ~owner_mem & io_master_rvalid;
                state_n = (io_master_rvalid & io_master_rready & io_master_rlast) ? IDLE : R;
            end
            default: state_n = IDLE;
        endcase
    end
    // state, grant latch and sticky response-error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            owner_mem <= 1'b0;
            araddr_q <= '0;
            arsize_q <= '0;
            arid_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            if (MEM_raddr_ready) begin
                owner_mem <= 1'b1;
                araddr_q <= MEM_raddr;
                arsize_q <= MEM_rsize;
                arid_q <= MEM_ID;
            end else if (IFU_raddr_ready) begin
                owner_mem <= 1'b0;
                araddr_q <= IFU_raddr;
                arsize_q <= IFU_rsize;
                arid_q <= IFU_ID;
            end
            if (beat & (io_master_rresp != 2'b00 | io_master_rid != arid_q | ~io_master_rlast))
                err_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: randomized transaction-level check of the two-master read arbiter
module tb_axi_read_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] IFU_raddr = '0, MEM_raddr = '0, io_master_araddr;
    logic [2:0] IFU_rsize = '0, MEM_rsize = '0, io_master_arsize;
    logic IFU_raddr_valid = 1'b0, MEM_raddr_valid = 1'b0, IFU_raddr_ready, MEM_raddr_ready;
    logic [63:0] IFU_rdata, MEM_rdata, io_master_rdata = '0;
    logic IFU_rdata_valid, MEM_rdata_valid, IFU_rdata_ready = 1'b0, MEM_rdata_ready = 1'b0;
    logic io_master_arready = 1'b0, io_master_arvalid, io_master_rready, io_master_rvalid = 1'b0;
    logic [3:0] io_master_arid, io_master_rid = '0;
    logic [7:0] io_master_arlen;
    logic [1:0] io_master_arburst, io_master_rresp = '0;
    logic io_master_rlast = 1'b0, ARB_error_signal;
    int errors = 0, checks = 0;
    logic err_model = 1'b0;

    axi_read_arbiter dut (
        .clk(clk), .rst(rst),
        .IFU_raddr(IFU_raddr), .IFU_rsize(IFU_rsize), .IFU_raddr_valid(IFU_raddr_valid),
        .IFU_raddr_ready(IFU_raddr_ready), .IFU_rdata(IFU_rdata), .IFU_rdata_valid(IFU_rdata_valid),
        .IFU_rdata_ready(IFU_rdata_ready),
        .MEM_raddr(MEM_raddr), .MEM_rsize(MEM_rsize), .MEM_raddr_valid(MEM_raddr_valid),
        .MEM_raddr_ready(MEM_raddr_ready), .MEM_rdata(MEM_rdata), .MEM_rdata_valid(MEM_rdata_valid),
        .MEM_rdata_ready(MEM_rdata_ready),
        .io_master_arready(io_master_arready), .io_master_arvalid(io_master_arvalid),
        .io_master_araddr(io_master_araddr), .io_master_arid(io_master_arid),
        .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
        .io_master_arburst(io_master_arburst), .io_master_rready(io_master_rready),
        .io_master_rvalid(io_master_rvalid), .io_master_rdata(io_master_rdata),
        .io_master_rresp(io_master_rresp), .io_master_rlast(io_master_rlast),
        .io_master_rid(io_master_rid), .ARB_error_signal(ARB_error_signal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_checks(input string tag);
        check({tag, "_arvalid"}, io_master_arvalid, 0);
        check({tag, "_rready"}, io_master_rready, 0);
        check({tag, "_rvalids"}, {IFU_rdata_valid, MEM_rdata_valid}, 0);
        check({tag, "_err"}, ARB_error_signal, err_model);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        err_model = 1'b0;
        sample();
        idle_checks("reset");
        check("reset_araddr", {io_master_araddr, io_master_arsize, io_master_arid}, 0);
        check("reset_up_ready", {IFU_raddr_ready, MEM_raddr_ready}, 0);
        tick();
    endtask

    // Serves one granted transaction starting the cycle after its upstream handshake.
    // bad: 0 clean, 1 rresp SLVERR, 2 wrong rid, 3 first beat without rlast.
    task automatic serve(input bit m, input logic [31:0] a, input logic [2:0] s, input logic [63:0] d,
                         input int ard, input int rvd, input int stall, input int bad);
        logic [3:0] id;
        int beats;
        id = m ? 4'd1 : 4'd0;
        beats = (bad == 3) ? 2 : 1;
        sample();
        check("arvalid_n1", io_master_arvalid, 1);
        check("araddr", io_master_araddr, a);
        check("arid", io_master_arid, id);
        check("arsize", io_master_arsize, s);
        check("arlen_burst", {io_master_arlen, io_master_arburst}, 10'b0000_0000_01);
        check("up_ready_busy", {IFU_raddr_ready, MEM_raddr_ready}, 0);
        for (int i = 0; i < ard; i++) begin
            tick();
            sample();
            check("ar_hold", {io_master_arvalid, io_master_araddr}, {1'b1, a});
        end
        io_master_arready = 1'b1;
        tick();
        io_master_arready = 1'b0;
        for (int i = 0; i < rvd; i++) begin
            sample();
            check("r_wait_valid", {IFU_rdata_valid, MEM_rdata_valid, io_master_arvalid}, 0);
            tick();
        end
        for (int b = 0; b < beats; b++) begin
            io_master_rvalid = 1'b1;
            io_master_rdata = d + 64'(b);
            io_master_rresp = (bad == 1) ? 2'b10 : 2'b00;
            io_master_rid = (bad == 2) ? (id ^ 4'd1) : id;
            io_master_rlast = (b == beats - 1);
            for (int i = 0; i < (b == 0 ? stall : 0); i++) begin
                {MEM_rdata_ready, IFU_rdata_ready} = m ? 2'b01 : 2'b10;
                sample();
                check("stall_rready", io_master_rready, 0);
                check("stall_own_valid", m ? MEM_rdata_valid : IFU_rdata_valid, 1);
                tick();
            end
            {MEM_rdata_ready, IFU_rdata_ready} = m ? 2'b10 : 2'b01;
            sample();
            check("beat_rready", io_master_rready, 1);
            check("beat_own_valid", m ? MEM_rdata_valid : IFU_rdata_valid, 1);
            check("beat_other_valid", m ? IFU_rdata_valid : MEM_rdata_valid, 0);
            check("beat_data", m ? MEM_rdata : IFU_rdata, d + 64'(b));
            check("beat_err_pre", ARB_error_signal, err_model);
            tick();
            if (bad != 0) err_model = 1'b1;
            io_master_rvalid = 1'b0;
            {MEM_rdata_ready, IFU_rdata_ready} = 2'b00;
        end
        sample();
        idle_checks("done");
    endtask

    // Presents up to two simultaneous requests; the reference rule is that MEM wins and IFU waits.
    task automatic run(input bit mv, input bit iv, input logic [31:0] ma, input logic [31:0] ia,
                       input logic [63:0] d, input int ard, input int rvd, input int stall, input int bad);
        logic [2:0] ms, is;
        ms = 3'($urandom_range(0, 3));
        is = (mv || ia != 32'h8000_0000) ? 3'($urandom_range(0, 3)) : 3'b010;
        MEM_raddr = ma;
        MEM_rsize = ms;
        MEM_raddr_valid = mv;
        IFU_raddr = ia;
        IFU_rsize = is;
        IFU_raddr_valid = iv;
        sample();
        check("mem_raddr_ready", MEM_raddr_ready, mv);
        check("ifu_raddr_ready", IFU_raddr_ready, iv & ~mv);
        tick();
        if (mv) begin
            MEM_raddr_valid = 1'b0;
            serve(1'b1, ma, ms, d, ard, rvd, stall, bad);
            if (iv) begin
                check("ifu_granted_after", {IFU_raddr_ready, MEM_raddr_ready}, 2'b10);
                tick();
                IFU_raddr_valid = 1'b0;
                serve(1'b0, ia, is, {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 2),
                      $urandom_range(0, 2), 0);
            end
        end else begin
            IFU_raddr_valid = 1'b0;
            serve(1'b0, ia, is, d, ard, rvd, stall, bad);
        end
        tick();
    endtask

    initial begin
        do_reset();
        run(1'b0, 1'b1, 32'h0, 32'h8000_0000, 64'h1122_3344_5566_7788, 2, 0, 0, 0);
        run(1'b1, 1'b1, 32'hA000_0004, 32'h8000_0010, 64'hCAFE_0000_0000_0001, 1, 1, 0, 0);
        run(1'b1, 1'b0, 32'hA000_0100, 32'h0, 64'h0BAD_F00D_0000_0002, 0, 0, 3, 0);
        run(1'b0, 1'b1, 32'h0, 32'h8000_0020, 64'h0000_0000_DEAD_BEEF, 0, 0, 0, 2);
        run(1'b0, 1'b1, 32'h0, 32'h8000_0024, 64'h1, 0, 0, 0, 0);
        run(1'b1, 1'b0, 32'hA000_0008, 32'h0, 64'h2, 0, 1, 0, 1);
        run(1'b1, 1'b1, 32'hA000_000C, 32'h8000_0028, 64'h3, 1, 0, 1, 0);
        IFU_raddr = 32'h8000_0040;
        IFU_raddr_valid = 1'b1;
        sample();
        check("rst_test_ready", IFU_raddr_ready, 1);
        tick();
        IFU_raddr_valid = 1'b0;
        sample();
        check("rst_test_arvalid", io_master_arvalid, 1);
        rst = 1'b1;
        tick();
        sample();
        err_model = 1'b0;
        idle_checks("mid_rst");
        check("mid_rst_up_ready", {IFU_raddr_ready, MEM_raddr_ready}, 0);
        tick();
        rst = 1'b0;
        run(1'b0, 1'b1, 32'h0, 32'h8000_0044, 64'h4, 0, 0, 0, 0);
        run(1'b1, 1'b0, 32'hA000_0010, 32'h0, 64'h5, 0, 0, 0, 3);
        for (int n = 0; n < 60; n++) begin
            bit mv, iv;
            int bad;
            if (n % 15 == 14) do_reset();
            mv = 1'($urandom_range(0, 1));
            iv = mv ? 1'($urandom_range(0, 1)) : 1'b1;
            bad = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
            run(mv, iv, $urandom, $urandom, {$urandom, $urandom}, $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3), bad);
            for (int g = 0; g < $urandom_range(0, 2); g++) begin
                sample();
                idle_checks("gap");
                tick();
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
